id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register and load-use stall controller for the 8-bit RISC-RNS core. It captures decoded operands, after ID-stage bypass, plus control from ID each cycle, and presents them as the *_IDtoEX fields consumed by the EX-stage forwarding logic. It detects a load in EX whose destination is read by the instruction in ID, then inserts LOAD_LAT bubbles while holding PC and IF/ID. It squashes on a branch flush.

Parameters:
NUM_DOMAINS, 1, number of 8-bit RNS residue lanes carried per op1/op2 data field
LOAD_LAT, 1, bubble cycles inserted per load-use hazard (1..7)
ALU_OP_W, 5, width of ALU opcode field

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
valid_ID  in  1  ID holds a real instruction
op1_addr_ID  in  4  source reg 1 address
op2_addr_ID  in  4  source reg 2 address
op3_addr_ID  in  3  source reg 3 address (binary-domain regfile)
use_op1_ID / use_op2_ID / use_op3_ID  in  1 each  instruction actually reads that operand
op1_data_ID  in  NUM_DOMAINS*8  op1 after ID bypass
op2_data_ID  in  NUM_DOMAINS*8  op2 after ID bypass
op3_data_ID  in  8  op3 after ID bypass
dest_addr_ID  in  4  destination register
reg_wr_en_ID, load_true_ID, store_true_ID  in  1 each  control flags
alu_op_ID  in  ALU_OP_W  ALU opcode
flush_EX  in  1  taken branch/jump resolved in EX; squash ID and the ID/EX register
valid_IDtoEX  out  1  EX slot holds a real instruction
op1_addr_IDtoEX, op2_addr_IDtoEX  out  4  registered addresses
op3_addr_IDtoEX  out  3  registered address
op1_data_IDtoEX, op2_data_IDtoEX  out  NUM_DOMAINS*8  registered data
op3_data_IDtoEX  out  8  registered data
dest_addr_IDtoEX  out  4  registered destination
reg_wr_en_IDtoEX, load_true_EX, store_true_IDtoEX  out  1 each  registered control
alu_op_IDtoEX  out  ALU_OP_W  registered opcode
stall_IFID  out  1  combinational; hold PC and IF/ID register this cycle

Behaviour:
- Reset (rst=1 at edge): state=RUN, counter=0, every registered output =0. stall_IFID=0 while rst=1.
- Hazard (comb, state RUN): valid_ID & valid_IDtoEX & load_true_EX & reg_wr_en_IDtoEX & (
  (use_op1_ID & op1_addr_ID==dest_addr_IDtoEX) | (use_op2_ID & op2_addr_ID==dest_addr_IDtoEX) |
  (use_op3_ID & {1'b0,op3_addr_ID}==dest_addr_IDtoEX) ).
- FSM states RUN, STALL; cnt is 3 bits.
  RUN, no hazard: register loads ID fields; stall_IFID=0.
  RUN, hazard: register loads bubble; stall_IFID=1; cnt<=LOAD_LAT-1; next=STALL if LOAD_LAT>1, else RUN.
  STALL: register loads bubble; stall_IFID=1; cnt decrements; at cnt==1 the next state is RUN, and stall_IFID=1 still holds that cycle. Hazard detection is ignored in STALL.
- Net effect: the dependent instruction enters EX exactly LOAD_LAT+1 cycles after the load entered EX.
- Bubble: valid, reg_wr_en, load_true, store_true, alu_op, dest, addrs and data all =0.
- flush_EX=1 has priority over everything except rst. The register loads a bubble, state->RUN, cnt->0, stall_IFID=0. Upstream squashes IF/ID itself.
- Simultaneous hazard and flush: flush wins; no stall is started.
- rst mid-STALL: returns to RUN next edge with all outputs zero.
- Fields are widths-exact; op3 zero-extension is used only for the comparison.

Decomposition:
- Shared package rns_pipe_pkg: REG_ADDR_W=4, REG3_ADDR_W=3, LANE_W=8, ALU_OP_W, state encoding (ST_RUN=1'b0, ST_STALL=1'b1), bubble constant for the control bundle.
- One natural sub-module: load_use_detect. It is purely combinational and implements the hazard equation, so it can be unit-tested in isolation.
- The FSM, counter and pipeline register stay in id_ex_stage.

Test Plan:
- rst held 2 cycles with random inputs -> all outputs 0, stall_IFID=0; first edge after release with valid_ID=1, op1_data=8'h2A -> op1_data_IDtoEX=8'h2A, valid_IDtoEX=1.
- LD r3 in EX (load_true_EX=1, dest=3), ID ADD r1,r3,use_op2=1, LOAD_LAT=1 -> stall_IFID=1 one cycle, one bubble (valid_IDtoEX=0), then ADD appears in EX.
- Same sequence with LOAD_LAT=3 -> stall_IFID=1 for 3 consecutive cycles, 3 bubbles, ADD enters EX on the 4th edge after the load entered EX.
- LD r3 in EX, ID reads r3 with use_op2=0, or reads r5 -> no stall, instruction advances normally.
- LD r2 in EX, ID op3_addr=3'd2, use_op3=1 -> stall. Dest=4'd10, op3_addr=3'd2 -> no stall (zero-extend check).
- Hazard and flush_EX=1 same cycle -> bubble, stall_IFID=0, state RUN. Flush in the 2nd cycle of a LOAD_LAT=3 stall -> stall ends immediately. rst asserted mid-STALL -> outputs 0 next edge.

Source files
------------

// File: rtl/rns_pipe_pkg.sv
// Shared constants and types for the RISC-RNS pipeline registers.
package rns_pipe_pkg;
  localparam int REG_ADDR_W  = 4;
  localparam int REG3_ADDR_W = 3;
  localparam int LANE_W      = 8;
  localparam int ALU_OP_W    = 5;

  // ID/EX stall FSM encoding
  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_STALL = 1'b1;

  // Single-bit control flags that travel with each instruction
  typedef struct packed {
    logic valid;
    logic reg_wr_en;
    logic load;
    logic store;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{valid: 1'b0, reg_wr_en: 1'b0, load: 1'b0, store: 1'b0};
endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector: a load in EX writes a register
// that the instruction in ID actually reads.
module load_use_detect
  import rns_pipe_pkg::*;
(
  input  logic                   id_valid_i,
  input  logic                   use_op1_i,
  input  logic                   use_op2_i,
  input  logic                   use_op3_i,
  input  logic [REG_ADDR_W-1:0]  op1_addr_i,
  input  logic [REG_ADDR_W-1:0]  op2_addr_i,
  input  logic [REG3_ADDR_W-1:0] op3_addr_i,
  input  logic                   ex_valid_i,
  input  logic                   ex_load_i,
  input  logic                   ex_wr_en_i,
  input  logic [REG_ADDR_W-1:0]  ex_dest_i,
  output logic                   hazard_o
);
  logic [REG_ADDR_W-1:0] op3_ext;
  logic                  src_match;

  // op3 lives in the narrower binary regfile; widen only for the compare
  assign op3_ext   = {1'b0, op3_addr_i};
  assign src_match = (use_op1_i & (op1_addr_i == ex_dest_i))
                   | (use_op2_i & (op2_addr_i == ex_dest_i))
                   | (use_op3_i & (op3_ext    == ex_dest_i));
  assign hazard_o  = id_valid_i & ex_valid_i & ex_load_i & ex_wr_en_i & src_match;
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall FSM and branch-flush squash.
module id_ex_stage
  import rns_pipe_pkg::*;
#(
  parameter int NUM_DOMAINS = 1,
  parameter int LOAD_LAT    = 1,
  parameter int ALU_OP_W    = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid_ID,
  input  logic [3:0]                    op1_addr_ID,
  input  logic [3:0]                    op2_addr_ID,
  input  logic [2:0]                    op3_addr_ID,
  input  logic                          use_op1_ID,
  input  logic                          use_op2_ID,
  input  logic                          use_op3_ID,
  input  logic [NUM_DOMAINS*8-1:0]      op1_data_ID,
  input  logic [NUM_DOMAINS*8-1:0]      op2_data_ID,
  input  logic [7:0]                    op3_data_ID,
  input  logic [3:0]                    dest_addr_ID,
  input  logic                          reg_wr_en_ID,
  input  logic                          load_true_ID,
  input  logic                          store_true_ID,
  input  logic [ALU_OP_W-1:0]           alu_op_ID,
  input  logic                          flush_EX,
  output logic                          valid_IDtoEX,
  output logic [3:0]                    op1_addr_IDtoEX,
  output logic [3:0]                    op2_addr_IDtoEX,
  output logic [2:0]                    op3_addr_IDtoEX,
  output logic [NUM_DOMAINS*8-1:0]      op1_data_IDtoEX,
  output logic [NUM_DOMAINS*8-1:0]      op2_data_IDtoEX,
  output logic [7:0]                    op3_data_IDtoEX,
  output logic [3:0]                    dest_addr_IDtoEX,
  output logic                          reg_wr_en_IDtoEX,
  output logic                          load_true_EX,
  output logic                          store_true_IDtoEX,
  output logic [ALU_OP_W-1:0]           alu_op_IDtoEX,
  output logic                          stall_IFID
);
  localparam int DW = NUM_DOMAINS * LANE_W;

  logic                   state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   hazard;
  logic                   take_id;
  logic                   stall;

  ctrl_t                  ctrl_q;
  logic [3:0]             op1_addr_q, op2_addr_q, dest_q;
  logic [2:0]             op3_addr_q;
  logic [DW-1:0]          op1_data_q, op2_data_q;
  logic [7:0]             op3_data_q;
  logic [ALU_OP_W-1:0]    alu_op_q;

  load_use_detect u_detect (
    .id_valid_i (valid_ID),
    .use_op1_i  (use_op1_ID),
    .use_op2_i  (use_op2_ID),
    .use_op3_i  (use_op3_ID),
    .op1_addr_i (op1_addr_ID),
    .op2_addr_i (op2_addr_ID),
    .op3_addr_i (op3_addr_ID),
    .ex_valid_i (ctrl_q.valid),
    .ex_load_i  (ctrl_q.load),
    .ex_wr_en_i (ctrl_q.reg_wr_en),
    .ex_dest_i  (dest_q),
    .hazard_o   (hazard)
  );

  // Stall FSM: flush beats everything; hazards are only looked at in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take_id = 1'b0;
    stall   = 1'b0;
    if (flush_EX) begin
      state_d = ST_RUN;
      cnt_d   = 3'd0;
    end else if (state_q == ST_RUN) begin
      if (hazard) begin
        stall   = 1'b1;
        cnt_d   = 3'(LOAD_LAT - 1);
        state_d = (LOAD_LAT > 1) ? ST_STALL : ST_RUN;
      end else begin
        take_id = 1'b1;
      end
    end else begin
      stall = 1'b1;
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) state_d = ST_RUN;
    end
  end

  assign stall_IFID = stall & ~rst;

  // Pipeline register: capture ID fields or insert an all-zero bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cnt_q      <= 3'd0;
      ctrl_q     <= CTRL_BUBBLE;
      op1_addr_q <= '0;
      op2_addr_q <= '0;
      op3_addr_q <= '0;
      op1_data_q <= '0;
      op2_data_q <= '0;
      op3_data_q <= '0;
      dest_q     <= '0;
      alu_op_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take_id) begin
        ctrl_q     <= '{valid: valid_ID, reg_wr_en: reg_wr_en_ID,
                        load: load_true_ID, store: store_true_ID};
        op1_addr_q <= op1_addr_ID;
        op2_addr_q <= op2_addr_ID;
        op3_addr_q <= op3_addr_ID;
        op1_data_q <= op1_data_ID;
        op2_data_q <= op2_data_ID;
        op3_data_q <= op3_data_ID;
        dest_q     <= dest_addr_ID;
        alu_op_q   <= alu_op_ID;
      end else begin
        ctrl_q     <= CTRL_BUBBLE;
        op1_addr_q <= '0;
        op2_addr_q <= '0;
        op3_addr_q <= '0;
        op1_data_q <= '0;
        op2_data_q <= '0;
        op3_data_q <= '0;
        dest_q     <= '0;
        alu_op_q   <= '0;
      end
    end
  end

  assign valid_IDtoEX      = ctrl_q.valid;
  assign reg_wr_en_IDtoEX  = ctrl_q.reg_wr_en;
  assign load_true_EX      = ctrl_q.load;
  assign store_true_IDtoEX = ctrl_q.store;
  assign op1_addr_IDtoEX   = op1_addr_q;
  assign op2_addr_IDtoEX   = op2_addr_q;
  assign op3_addr_IDtoEX   = op3_addr_q;
  assign op1_data_IDtoEX   = op1_data_q;
  assign op2_data_IDtoEX   = op2_data_q;
  assign op3_data_IDtoEX   = op3_data_q;
  assign dest_addr_IDtoEX  = dest_q;
  assign alu_op_IDtoEX     = alu_op_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench: two instances (LOAD_LAT=1 as "a", LOAD_LAT=3 as "b")
// share one stimulus stream.
module tb_id_ex_stage;
  logic       clk = 1'b0;
  logic       rst;
  logic       valid_ID, use_op1_ID, use_op2_ID, use_op3_ID;
  logic [3:0] op1_addr_ID, op2_addr_ID, dest_addr_ID;
  logic [2:0] op3_addr_ID;
  logic [7:0] op1_data_ID, op2_data_ID, op3_data_ID;
  logic       reg_wr_en_ID, load_true_ID, store_true_ID, flush_EX;
  logic [4:0] alu_op_ID;

  logic       a_valid, a_wr, a_ld, a_st, a_stall;
  logic [3:0] a_a1, a_a2, a_dest;
  logic [2:0] a_a3;
  logic [7:0] a_d1, a_d2, a_d3;
  logic [4:0] a_alu;
  logic       b_valid, b_wr, b_ld, b_st, b_stall;
  logic [3:0] b_a1, b_a2, b_dest;
  logic [2:0] b_a3;
  logic [7:0] b_d1, b_d2, b_d3;
  logic [4:0] b_alu;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.NUM_DOMAINS(1), .LOAD_LAT(1), .ALU_OP_W(5)) u_a (
    .clk(clk), .rst(rst), .valid_ID(valid_ID),
    .op1_addr_ID(op1_addr_ID), .op2_addr_ID(op2_addr_ID), .op3_addr_ID(op3_addr_ID),
    .use_op1_ID(use_op1_ID), .use_op2_ID(use_op2_ID), .use_op3_ID(use_op3_ID),
    .op1_data_ID(op1_data_ID), .op2_data_ID(op2_data_ID), .op3_data_ID(op3_data_ID),
    .dest_addr_ID(dest_addr_ID), .reg_wr_en_ID(reg_wr_en_ID), .load_true_ID(load_true_ID),
    .store_true_ID(store_true_ID), .alu_op_ID(alu_op_ID), .flush_EX(flush_EX),
    .valid_IDtoEX(a_valid), .op1_addr_IDtoEX(a_a1), .op2_addr_IDtoEX(a_a2),
    .op3_addr_IDtoEX(a_a3), .op1_data_IDtoEX(a_d1), .op2_data_IDtoEX(a_d2),
    .op3_data_IDtoEX(a_d3), .dest_addr_IDtoEX(a_dest), .reg_wr_en_IDtoEX(a_wr),
    .load_true_EX(a_ld), .store_true_IDtoEX(a_st), .alu_op_IDtoEX(a_alu),
    .stall_IFID(a_stall)
  );

  id_ex_stage #(.NUM_DOMAINS(1), .LOAD_LAT(3), .ALU_OP_W(5)) u_b (
    .clk(clk), .rst(rst), .valid_ID(valid_ID),
    .op1_addr_ID(op1_addr_ID), .op2_addr_ID(op2_addr_ID), .op3_addr_ID(op3_addr_ID),
    .use_op1_ID(use_op1_ID), .use_op2_ID(use_op2_ID), .use_op3_ID(use_op3_ID),
    .op1_data_ID(op1_data_ID), .op2_data_ID(op2_data_ID), .op3_data_ID(op3_data_ID),
    .dest_addr_ID(dest_addr_ID), .reg_wr_en_ID(reg_wr_en_ID), .load_true_ID(load_true_ID),
    .store_true_ID(store_true_ID), .alu_op_ID(alu_op_ID), .flush_EX(flush_EX),
    .valid_IDtoEX(b_valid), .op1_addr_IDtoEX(b_a1), .op2_addr_IDtoEX(b_a2),
    .op3_addr_IDtoEX(b_a3), .op1_data_IDtoEX(b_d1), .op2_data_IDtoEX(b_d2),
    .op3_data_IDtoEX(b_d3), .dest_addr_IDtoEX(b_dest), .reg_wr_en_IDtoEX(b_wr),
    .load_true_EX(b_ld), .store_true_IDtoEX(b_st), .alu_op_IDtoEX(b_alu),
    .stall_IFID(b_stall)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_ID = 0; use_op1_ID = 0; use_op2_ID = 0; use_op3_ID = 0;
    op1_addr_ID = 0; op2_addr_ID = 0; op3_addr_ID = 0; dest_addr_ID = 0;
    op1_data_ID = 0; op2_data_ID = 0; op3_data_ID = 0;
    reg_wr_en_ID = 0; load_true_ID = 0; store_true_ID = 0; alu_op_ID = 0;
  endtask

  task automatic rand_in();
    valid_ID = 1'($urandom); use_op1_ID = 1'($urandom); use_op2_ID = 1'($urandom);
    use_op3_ID = 1'($urandom); op1_addr_ID = 4'($urandom); op2_addr_ID = 4'($urandom);
    op3_addr_ID = 3'($urandom); dest_addr_ID = 4'($urandom); op1_data_ID = 8'($urandom);
    op2_data_ID = 8'($urandom); op3_data_ID = 8'($urandom); reg_wr_en_ID = 1'($urandom);
    load_true_ID = 1'($urandom); store_true_ID = 1'($urandom); alu_op_ID = 5'($urandom);
  endtask

  // squash both instances back to RUN with empty EX
  task automatic clear();
    idle();
    flush_EX = 1;
    tick();
    flush_EX = 0;
  endtask

  task automatic set_load(input logic [3:0] d);
    idle();
    valid_ID = 1; load_true_ID = 1; reg_wr_en_ID = 1; dest_addr_ID = d; alu_op_ID = 5'd9;
  endtask

  // ADD r1, r4, r3
  task automatic set_add();
    idle();
    valid_ID = 1; reg_wr_en_ID = 1; dest_addr_ID = 4'd1; alu_op_ID = 5'd3;
    use_op1_ID = 1; op1_addr_ID = 4'd4; op1_data_ID = 8'h11;
    use_op2_ID = 1; op2_addr_ID = 4'd3; op2_data_ID = 8'h22;
  endtask

  initial begin
    idle();
    flush_EX = 0;
    rst = 1;
    rand_in(); tick();
    rand_in(); tick();
    #1;
    chk("rst_valid_a", a_valid, 0);
    chk("rst_valid_b", b_valid, 0);
    chk("rst_ctrl_b", {b_wr, b_ld, b_st}, 0);
    chk("rst_fields_b", {b_a1, b_a2, b_a3, b_dest, b_alu}, 0);
    chk("rst_data_b", {b_d1, b_d2, b_d3}, 0);
    chk("rst_stall", {a_stall, b_stall}, 0);

    // first instruction after release
    rst = 0;
    idle();
    valid_ID = 1; op1_data_ID = 8'h2A; op3_data_ID = 8'h5C; store_true_ID = 1;
    tick();
    chk("rel_op1_a", a_d1, 8'h2A);
    chk("rel_valid_a", a_valid, 1);
    chk("rel_op1_b", b_d1, 8'h2A);
    chk("rel_op3_b", b_d3, 8'h5C);
    chk("rel_store_b", b_st, 1);

    // load-use on op2: LAT=1 one bubble, LAT=3 three bubbles
    clear();
    set_load(4'd3); tick();
    chk("ld_in_ex_b", b_ld, 1);
    set_add(); #1;
    chk("lu_stall0", {a_stall, b_stall}, 2'b11);
    tick();
    chk("lu_bub1", {a_valid, b_valid}, 0);
    chk("lu_stall1", {a_stall, b_stall}, 2'b01);
    tick();
    chk("lu_a_enter", {a_valid, a_alu, a_a2, a_d2}, {1'b1, 5'd3, 4'd3, 8'h22});
    chk("lu_b_bub2", b_valid, 0);
    chk("lu_stall2", {a_stall, b_stall}, 2'b01);
    tick();
    chk("lu_b_bub3", b_valid, 0);
    chk("lu_b_stall3", b_stall, 0);
    tick();
    chk("lu_b_enter", {b_valid, b_alu, b_dest, b_d1}, {1'b1, 5'd3, 4'd1, 8'h11});

    // operand not actually read, or different register: no stall
    clear();
    set_load(4'd3); tick();
    set_add(); use_op2_ID = 0; #1;
    chk("nouse_stall", {a_stall, b_stall}, 0);
    tick();
    chk("nouse_adv", {a_valid, b_valid}, 2'b11);
    clear();
    set_load(4'd3); tick();
    set_add(); op2_addr_ID = 4'd5; #1;
    chk("r5_stall", {a_stall, b_stall}, 0);

    // op3 comparison uses zero extension
    clear();
    set_load(4'd2); tick();
    set_add(); use_op2_ID = 0; use_op3_ID = 1; op3_addr_ID = 3'd2; #1;
    chk("op3_hit", {a_stall, b_stall}, 2'b11);
    clear();
    set_load(4'd10); tick();
    set_add(); use_op2_ID = 0; use_op3_ID = 1; op3_addr_ID = 3'd2; #1;
    chk("op3_zext", {a_stall, b_stall}, 0);

    // hazard and flush together: flush wins, no stall started
    clear();
    set_load(4'd3); tick();
    set_add(); flush_EX = 1; #1;
    chk("hf_stall", {a_stall, b_stall}, 0);
    tick();
    chk("hf_bubble", {a_valid, b_valid}, 0);
    flush_EX = 0; #1;
    chk("hf_run", {a_stall, b_stall}, 0);
    tick();
    chk("hf_enter", {a_valid, b_valid}, 2'b11);

    // flush in second cycle of LAT=3 stall ends it
    clear();
    set_load(4'd3); tick();
    set_add(); tick();
    chk("fm_in_stall", b_stall, 1);
    flush_EX = 1; #1;
    chk("fm_stall", b_stall, 0);
    tick();
    chk("fm_bubble", b_valid, 0);
    flush_EX = 0; #1;
    chk("fm_run", b_stall, 0);
    tick();
    chk("fm_enter", b_valid, 1);

    // reset in the middle of a stall
    clear();
    set_load(4'd3); tick();
    set_add(); tick();
    rst = 1; #1;
    chk("rm_stall", b_stall, 0);
    tick();
    chk("rm_zero", {b_valid, b_dest, b_alu, b_d1, b_d2}, 0);
    rst = 0; #1;
    chk("rm_run", b_stall, 0);
    tick();
    chk("rm_enter", {b_valid, b_d1}, {1'b1, 8'h11});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
